// File: rtl/fb_pkg.sv
// Shared types and default geometry for the double-buffered frame store.
package fb_pkg;

    localparam int DEF_H_RES     = 320;
    localparam int DEF_V_RES     = 240;
    localparam int DEF_ADDR_W    = 18;
    localparam int DEF_DATA_W    = 16;
    localparam int DEF_BUF1_BASE = 76800;

    typedef logic [DEF_DATA_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        START = 2'd0,
        CLEAR = 2'd1,
        DRAW  = 2'd2
    } state_t;

endpackage

// File: rtl/back_buffer_clear_edge_toggle_detect.sv
// Flags any change of a slow control bit (e.g. a vsync-derived frame select).
module edge_toggle_detect (
    input  logic Clk,
    input  logic Reset,
    input  logic in_bit,
    output logic toggle
);

    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = in_bit;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign toggle = in_bit ^ prev_q;

endmodule

// File: rtl/back_buffer_clear.sv
// Clears the hidden back buffer after every frame swap, then hands the buffer
// to the draw stage; flags frames where the swap arrives before the clear ends.
module back_buffer_clear
    import fb_pkg::*;
#(
    parameter int H_RES     = DEF_H_RES,
    parameter int V_RES     = DEF_V_RES,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BUF1_BASE = DEF_BUF1_BASE
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_num,
    input  logic [DATA_W-1:0] clear_color,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic              mem_ready,
    output logic              back_sel,
    output logic              clear_busy,
    output logic              draw_enable,
    output logic              frame_overrun
);

    localparam int NPIX  = H_RES * V_RES;
    localparam int IDX_W = $clog2(NPIX);

    generate
        if (BUF1_BASE + NPIX > (1 << ADDR_W)) begin : g_addr_range_check
            $error("back_buffer_clear: buffer 1 does not fit in the address space");
        end
    endgenerate

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               back_sel_q, back_sel_d;
    logic               overrun_q, overrun_d;
    logic               toggle;
    logic               accept;
    logic               last_word;
    logic [ADDR_W-1:0]  base;

    edge_toggle_detect u_toggle (
        .Clk    (Clk),
        .Reset  (Reset),
        .in_bit (frame_num),
        .toggle (toggle)
    );

    assign accept    = (state_q == CLEAR) && mem_ready;
    assign last_word = (idx_q == IDX_W'(NPIX - 1));
    assign base      = back_sel_q ? ADDR_W'(BUF1_BASE) : '0;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        back_sel_d  = back_sel_q;
        overrun_d   = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        clear_busy  = 1'b0;
        draw_enable = 1'b0;

        case (state_q)
            START: begin
                // A frame_num change seen here is simply absorbed into the first clear
                state_d    = CLEAR;
                back_sel_d = ~frame_num;
                idx_d      = '0;
            end
            CLEAR: begin
                mem_we     = 1'b1;
                mem_addr   = base + ADDR_W'(idx_q);
                mem_wdata  = clear_color;
                clear_busy = 1'b1;
                if (toggle) begin
                    // Restart on the new buffer; an accept this cycle still counts for the old one
                    back_sel_d = ~frame_num;
                    idx_d      = '0;
                    overrun_d  = !(accept && last_word);
                end else if (accept) begin
                    if (last_word) begin
                        state_d = DRAW;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DRAW: begin
                draw_enable = 1'b1;
                if (toggle) begin
                    state_d    = CLEAR;
                    back_sel_d = ~frame_num;
                    idx_d      = '0;
                end
            end
            default: begin
                state_d = START;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= START;
            idx_q      <= '0;
            back_sel_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            back_sel_q <= back_sel_d;
            overrun_q  <= overrun_d;
        end
    end

    assign back_sel      = back_sel_q;
    assign frame_overrun = overrun_q;

endmodule

// File: tb/tb_back_buffer_clear.sv
// Directed frame-swap scenarios plus randomized traffic against a behavioural model.
module tb_back_buffer_clear;

    localparam int H_RES     = 4;
    localparam int V_RES     = 2;
    localparam int NPIX      = H_RES * V_RES;
    localparam int ADDR_W    = 18;
    localparam int DATA_W    = 16;
    localparam int BUF1_BASE = 8;
    localparam logic [15:0] C = 16'hABCD;

    logic              Clk;
    logic              Reset;
    logic              frame_num;
    logic [DATA_W-1:0] clear_color;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_ready;
    logic              back_sel;
    logic              clear_busy;
    logic              draw_enable;
    logic              frame_overrun;

    back_buffer_clear #(
        .H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W),
        .DATA_W(DATA_W), .BUF1_BASE(BUF1_BASE)
    ) dut (
        .Clk(Clk), .Reset(Reset), .frame_num(frame_num), .clear_color(clear_color),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_ready(mem_ready), .back_sel(back_sel), .clear_busy(clear_busy),
        .draw_enable(draw_enable), .frame_overrun(frame_overrun)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int n_vec  = 0;
    int n_fail = 0;

    // Behavioural model: is a clear running, which buffer, how many words written
    bit m_valid   = 0;
    bit m_started = 0;
    bit m_clearing = 0;
    int m_buf     = 0;
    int m_cnt     = 0;
    bit m_prev    = 0;
    bit m_ovr     = 0;

    // Snapshots of the DUT outputs from the most recent sample point
    int s_addr, s_wdata;
    bit s_we, s_busy, s_draw, s_bsel, s_ovr;
    int acc_q[$];
    int busy_cnt;
    bit ovr_seen;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit fn, input bit rdy);
        bit tog;
        bit done;
        if (rst) begin
            m_valid = 1; m_started = 0; m_clearing = 0;
            m_buf = 0; m_cnt = 0; m_prev = 0; m_ovr = 0;
            return;
        end
        tog    = (fn != m_prev);
        m_prev = fn;
        if (!m_started) begin
            m_started = 1; m_clearing = 1; m_buf = fn ? 0 : 1; m_cnt = 0; m_ovr = 0;
        end else if (m_clearing) begin
            done = rdy && (m_cnt == NPIX - 1);
            if (tog) begin
                m_ovr = !done; m_buf = fn ? 0 : 1; m_cnt = 0;
            end else begin
                m_ovr = 0;
                if (done) begin
                    m_clearing = 0; m_cnt = 0;
                end else if (rdy) begin
                    m_cnt++;
                end
            end
        end else begin
            m_ovr = 0;
            if (tog) begin
                m_clearing = 1; m_buf = fn ? 0 : 1; m_cnt = 0;
            end
        end
    endtask

    task automatic cycle(input bit rst, input bit fn, input bit rdy, input logic [15:0] col);
        bit e_we;
        @(negedge Clk);
        Reset = rst; frame_num = fn; mem_ready = rdy; clear_color = col;
        #1;
        s_addr = int'(mem_addr); s_wdata = int'(mem_wdata); s_we = mem_we;
        s_busy = clear_busy; s_draw = draw_enable; s_bsel = back_sel; s_ovr = frame_overrun;
        if (s_we && rdy) acc_q.push_back(s_addr);
        if (s_busy) busy_cnt++;
        if (s_ovr) ovr_seen = 1;
        if (m_valid) begin
            e_we = m_started && m_clearing;
            chk("mem_we", int'(mem_we), int'(e_we));
            chk("mem_addr", int'(mem_addr), e_we ? (m_buf * BUF1_BASE + m_cnt) : 0);
            chk("mem_wdata", int'(mem_wdata), e_we ? int'(col) : 0);
            chk("clear_busy", int'(clear_busy), int'(e_we));
            chk("draw_enable", int'(draw_enable), int'(m_started && !m_clearing));
            chk("back_sel", int'(back_sel), m_buf);
            chk("frame_overrun", int'(frame_overrun), int'(m_ovr));
        end
        @(posedge Clk);
        model_step(rst, fn, rdy);
    endtask

    initial begin
        Reset = 1'b1; frame_num = 1'b0; mem_ready = 1'b1; clear_color = C;

        // Reset state
        cycle(1, 0, 1, C);
        cycle(1, 0, 1, C);
        chk("rst_we", s_we, 0);
        chk("rst_addr", s_addr, 0);
        chk("rst_draw", s_draw, 0);
        chk("rst_busy", s_busy, 0);
        chk("rst_bsel", s_bsel, 0);
        chk("rst_ovr", s_ovr, 0);

        // First clear after reset: buffer 1, addresses 8..15
        cycle(0, 0, 1, C);
        chk("start_we", s_we, 0);
        acc_q.delete();
        for (int i = 0; i < 8; i++) begin
            cycle(0, 0, 1, C);
            chk("clr1_data", s_wdata, 16'hABCD);
        end
        chk("clr1_count", acc_q.size(), 8);
        foreach (acc_q[i]) chk("clr1_addr", acc_q[i], 8 + i);
        chk("clr1_bsel", s_bsel, 1);
        cycle(0, 0, 1, C);
        chk("clr1_draw", s_draw, 1);

        // Swap from DRAW: buffer 0 cleared, no overrun
        ovr_seen = 0;
        cycle(0, 1, 1, C);
        chk("swap_draw_still", s_draw, 1);
        acc_q.delete();
        cycle(0, 1, 1, C);
        chk("swap_draw_off", s_draw, 0);
        chk("swap_bsel", s_bsel, 0);
        for (int i = 0; i < 7; i++) cycle(0, 1, 1, C);
        cycle(0, 1, 1, C);
        chk("clr0_draw", s_draw, 1);
        chk("clr0_count", acc_q.size(), 8);
        foreach (acc_q[i]) chk("clr0_addr", acc_q[i], i);
        chk("clr0_no_ovr", ovr_seen, 0);

        // Back-pressure: ready low for 3 cycles at idx 4
        cycle(0, 0, 1, C);
        acc_q.delete();
        busy_cnt = 0;
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, C);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, C);
            chk("stall_addr", s_addr, 12);
            chk("stall_we", s_we, 1);
        end
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, C);
        cycle(0, 0, 1, C);
        chk("stall_draw", s_draw, 1);
        chk("stall_cycles", busy_cnt, 11);
        chk("stall_count", acc_q.size(), 8);
        foreach (acc_q[i]) chk("stall_addr_seq", acc_q[i], 8 + i);

        // Swap mid-clear at idx 5: overrun pulse, restart at new base
        cycle(0, 1, 1, C);
        acc_q.delete();
        for (int i = 0; i < 5; i++) cycle(0, 1, 1, C);
        cycle(0, 0, 1, C);
        chk("ovr_tog_addr", s_addr, 5);
        cycle(0, 0, 1, C);
        chk("ovr_pulse", s_ovr, 1);
        chk("ovr_restart_addr", s_addr, 8);
        chk("ovr_restart_bsel", s_bsel, 1);
        cycle(0, 0, 1, C);
        chk("ovr_pulse_end", s_ovr, 0);
        chk("ovr_next_addr", s_addr, 9);
        for (int i = 0; i < 6; i++) cycle(0, 0, 1, C);
        cycle(0, 0, 1, C);
        chk("ovr_draw", s_draw, 1);
        chk("ovr_count", acc_q.size(), 14);
        chk("ovr_old_last", acc_q[5], 5);
        chk("ovr_new_first", acc_q[6], 8);

        // Swap on the same cycle as the final accept of buffer 1
        cycle(0, 1, 1, C);
        for (int i = 0; i < 8; i++) cycle(0, 1, 1, C);
        cycle(0, 1, 1, C);
        chk("pre_last_draw", s_draw, 1);
        cycle(0, 0, 1, C);
        for (int i = 0; i < 7; i++) cycle(0, 0, 1, C);
        cycle(0, 1, 1, C);
        chk("last_tog_addr", s_addr, 15);
        cycle(0, 1, 1, C);
        chk("last_no_ovr", s_ovr, 0);
        chk("last_addr0", s_addr, 0);
        chk("last_we", s_we, 1);
        chk("last_draw", s_draw, 0);
        chk("last_bsel", s_bsel, 0);

        // Reset at idx 3
        cycle(0, 1, 1, C);
        cycle(0, 1, 1, C);
        cycle(1, 1, 1, C);
        chk("midrst_addr", s_addr, 3);
        cycle(0, 1, 1, C);
        chk("midrst_we", s_we, 0);
        chk("midrst_busy", s_busy, 0);
        chk("midrst_draw", s_draw, 0);
        cycle(0, 1, 1, C);
        chk("midrst_restart_we", s_we, 1);
        chk("midrst_restart_addr", s_addr, 0);

        // Randomized traffic
        begin
            bit fn = 1;
            for (int i = 0; i < 3000; i++) begin
                bit rst;
                bit rdy;
                rst = ($urandom % 250) == 0;
                if (($urandom % 15) == 0) fn = ~fn;
                rdy = ($urandom % 4) != 0;
                cycle(rst, fn, rdy, 16'($urandom));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
